cell_fifo_reader: RTL and testbench
===================================

CELL_FIFO_READER -- requirements
Module: cell_fifo_reader

Interface
REQ-001 Parameter DWIDTH, default 8, sets the width of a data word.
REQ-002 Parameter CWIDTH, default 2, sets the width of the word address inside a cell.
REQ-003 Parameter CELL_WORDS, default 4, sets the words per cell; legal range 2..2^CWIDTH.
REQ-004 Parameter U_DLY, default 1, sets the simulation delay on register assignments.
REQ-005 i_clk_sys  in  1  the single clock; all logic is on its rising edge.
REQ-006 i_rst_n  in  1  reset, synchronous and active-low.
REQ-007 i_fifo_empty  in  1  cell FIFO empty flag; high means no complete cell is stored.
REQ-008 i_fifo_rdata  in  DWIDTH  pre-read data; it is valid for the current word while a cell is stored.
REQ-009 o_fifo_ren  out  1  read enable; consumes the current word.
REQ-010 o_fifo_reoc  out  1  read end of cell; pulses together with o_fifo_ren on the last word.
REQ-011 o_fifo_raddr  out  CWIDTH  word index inside the cell currently being read.
REQ-012 o_valid / i_ready  out / in  1 each  downstream handshake; a transfer occurs when both are high.
REQ-013 o_data  out  DWIDTH  downstream data word.
REQ-014 o_sop / o_eop  out  1 each  mark word 0 and word CELL_WORDS-1 of a cell; qualified by o_valid.
REQ-015 o_cell_cnt  out  16  count of cells fully read from the FIFO.
REQ-016 o_busy  out  1  high while the FSM is not in IDLE or the buffer is non-empty.

Function
REQ-017 The FSM SHALL have two states: IDLE and READ.
- IDLE -> READ when i_fifo_empty=0.
- READ -> IDLE on the cycle the last word is read.
REQ-018 The block SHALL assert o_fifo_ren only in READ and only when the registered buffer count is below 2.
- There is no combinational path from i_ready to o_fifo_ren.
REQ-019 A word counter SHALL drive o_fifo_raddr.
- It is 0 on entry to READ and increments on each o_fifo_ren.
- It returns to 0 after the last word.
REQ-020 o_fifo_reoc SHALL equal o_fifo_ren AND (word counter == CELL_WORDS-1); it is never asserted without o_fifo_ren.
REQ-021 The block SHALL spend exactly one IDLE cycle between consecutive cells.
- In that cycle, i_fifo_empty reflects the cell just released.
- Back-to-back cells therefore cost CELL_WORDS+1 cycles at full throughput.
REQ-022 Each o_fifo_ren SHALL push {i_fifo_rdata, sop=(counter==0), eop=o_fifo_reoc} into a 2-entry output FIFO buffer.
REQ-023 Latency: a word read at cycle t SHALL be presented on o_data at cycle t+1 at the earliest.
REQ-024 The buffer SHALL hold its head stable while o_valid=1 and i_ready=0.
REQ-025 Words SHALL leave the buffer in the order they were read; push and pop may occur in the same cycle, and the count is then unchanged.
REQ-026 With i_ready held high, the block SHALL sustain one word per cycle within a cell.
REQ-027 o_cell_cnt SHALL increment by 1 on each o_fifo_reoc and wrap from 0xFFFF to 0.
REQ-028 i_fifo_empty rising mid-cell (protocol violation) SHALL NOT abort the cell; all CELL_WORDS words are still read.

Reset
REQ-029 While i_rst_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- clear the word counter, the buffer count and o_cell_cnt;
- drive o_fifo_ren=0, o_fifo_reoc=0, o_fifo_raddr=0, o_valid=0, o_sop=0, o_eop=0, o_data=0, o_busy=0.
REQ-030 A reset in the middle of a cell SHALL discard the partial cell and all buffered words, and SHALL NOT pulse o_fifo_reoc.

Verification
REQ-031 Single cell, i_ready=1, CELL_WORDS=4, data A0..A3:
- o_fifo_raddr steps 0,1,2,3 on consecutive cycles;
- reoc is high with raddr=3;
- o_data is A0..A3 on consecutive cycles, sop on A0 and eop on A3;
- o_cell_cnt=1.
REQ-032 Three cells queued, i_ready=1:
- 12 words out in 14 cycles from the first ren, with one bubble between cells;
- o_cell_cnt=3, then the FSM stays in IDLE once empty=1.
REQ-033 Backpressure, i_ready=0 for 5 cycles from the first o_valid:
- at most 2 ren pulses occur;
- the held o_data=A0 stays stable;
- after i_ready rises, A0..A3 are delivered in order with none lost or duplicated.
REQ-034 Random i_ready (50%) over 100 cells of counting data:
- the output word sequence exactly matches the input;
- exactly 100 sop and 100 eop;
- o_cell_cnt=100.
REQ-035 Reset asserted after raddr=1 mid-cell:
- on the next edge all outputs are 0;
- no reoc pulse occurs;
- o_busy=0.
REQ-036 Preset o_cell_cnt=0xFFFF and read one cell -> o_cell_cnt=0x0000.

Source files
------------

// File: rtl/cell_fifo_reader.sv
// cell_fifo_reader: drains whole cells from a cell FIFO (pre-read data,
// word-addressed) and forwards the words through a 2-entry output buffer
// to a valid/ready downstream port, tagging the first and last word of
// every cell.
module cell_fifo_reader #(
    parameter int DWIDTH     = 8,
    parameter int CWIDTH     = 2,
    parameter int CELL_WORDS = 4,
    parameter int U_DLY      = 1
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic              i_fifo_empty,
    input  logic [DWIDTH-1:0] i_fifo_rdata,
    output logic              o_fifo_ren,
    output logic              o_fifo_reoc,
    output logic [CWIDTH-1:0] o_fifo_raddr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_sop,
    output logic              o_eop,
    output logic [15:0]       o_cell_cnt,
    output logic              o_busy,
    output logic              o_dbg_state
);

    // Downstream handshake: o_valid/o_data/o_sop/o_eop come straight from
    // registers and stay stable while o_valid=1 and i_ready=0; a word is
    // transferred on each rising edge where o_valid and i_ready are both 1.
    // i_ready never feeds o_fifo_ren combinationally.

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_READ   = 1'b1;
    localparam logic [CWIDTH-1:0] LAST_WORD = CWIDTH'(CELL_WORDS - 1);

    // U_DLY exists for compatibility with older simulation-delay builds;
    // registers here update without delay.
    generate
        if (CELL_WORDS < 2 || CELL_WORDS > (1 << CWIDTH) || U_DLY < 0) begin : g_param_check
            $error("cell_fifo_reader: illegal parameter set");
        end
    endgenerate

    logic [0:0]        state;
    logic [CWIDTH-1:0] word_cnt;
    logic [1:0]        buf_cnt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DWIDTH-1:0] buf_data [2];
    logic [1:0]        buf_sop;
    logic [1:0]        buf_eop;
    logic [15:0]       cell_cnt;

    logic              last_word;
    logic              ren;
    logic              reoc;
    logic              pop;

    // Read only while a cell is open and the buffer has room; the reset
    // gate keeps a reset-cycle read (and its end-of-cell) off the FIFO.
    assign last_word = (word_cnt == LAST_WORD);
    assign ren       = i_rst_n && (state == ST_READ) && (buf_cnt < 2'd2);
    assign reoc      = ren && last_word;
    assign pop       = (buf_cnt != 2'd0) && i_ready;

    // Cell-level FSM: open a cell when one is stored, close it on its last word.
    // Empty is ignored while reading so a mid-cell glitch cannot truncate a cell.
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (!i_fifo_empty) begin
                state <= ST_READ;
            end
        end else if (reoc) begin
            state <= ST_IDLE;
        end
    end

    // Word address inside the cell; wraps to 0 after the last word.
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            word_cnt <= '0;
        end else if (ren) begin
            if (last_word) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Two-entry output buffer; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            buf_cnt <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_sop <= 2'b00;
            buf_eop <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            if (ren) begin
                buf_data[wr_ptr] <= i_fifo_rdata;
                buf_sop[wr_ptr]  <= (word_cnt == '0);
                buf_eop[wr_ptr]  <= last_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (ren && !pop) begin
                buf_cnt <= buf_cnt + 2'd1;
            end else if (!ren && pop) begin
                buf_cnt <= buf_cnt - 2'd1;
            end
        end
    end

    // Completed-cell counter, free-running modulo 2^16.
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            cell_cnt <= 16'd0;
        end else if (reoc) begin
            cell_cnt <= cell_cnt + 16'd1;
        end
    end

    assign o_fifo_ren   = ren;
    assign o_fifo_reoc  = reoc;
    assign o_fifo_raddr = word_cnt;
    assign o_valid      = (buf_cnt != 2'd0);
    assign o_data       = buf_data[rd_ptr];
    assign o_sop        = o_valid && buf_sop[rd_ptr];
    assign o_eop        = o_valid && buf_eop[rd_ptr];
    assign o_cell_cnt   = cell_cnt;
    assign o_busy       = (state != ST_IDLE) || (buf_cnt != 2'd0);
    assign o_dbg_state  = state;

endmodule

// File: tb/tb_cell_fifo_reader.sv
// tb_cell_fifo_reader: directed bench for cell_fifo_reader (4-word cells).
// A small cell-FIFO source model answers o_fifo_ren; a scoreboard queue
// holds the expected {sop, eop, data} stream.
module tb_cell_fifo_reader;

    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_ren;
    logic       fifo_reoc;
    logic [1:0] fifo_raddr;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [15:0] cell_cnt;
    logic       busy;
    logic       dbg_state;

    cell_fifo_reader dut (
        .i_clk_sys    (clk),
        .i_rst_n      (rst_n),
        .i_fifo_empty (fifo_empty),
        .i_fifo_rdata (fifo_rdata),
        .o_fifo_ren   (fifo_ren),
        .o_fifo_reoc  (fifo_reoc),
        .o_fifo_raddr (fifo_raddr),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (data),
        .o_sop        (sop),
        .o_eop        (eop),
        .o_cell_cnt   (cell_cnt),
        .o_busy       (busy),
        .o_dbg_state  (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed time limit expected finish");
        $fatal(1, "watchdog");
    end

    // bench state
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] src_q[$];
    int         src_cells = 0;
    logic [9:0] exp_q[$];
    logic [1:0] exp_raddr = 2'd0;
    int         ren_cyc_q[$];
    int         out_cyc_q[$];
    int         ren_n, reoc_n, out_n, sop_n, eop_n;
    logic       rand_ready = 1'b0;

    logic       s_ren, s_reoc, s_valid, s_ready, s_sop, s_eop, s_busy, s_state;
    logic [1:0] s_raddr;
    logic [7:0] s_data;
    logic [15:0] s_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        fifo_empty = (src_cells == 0);
        fifo_rdata = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    task automatic load_cell(input logic [7:0] base);
        for (int k = 0; k < 4; k++) begin
            src_q.push_back(base + 8'(k));
            exp_q.push_back({(k == 0), (k == 3), 8'(base + 8'(k))});
        end
        src_cells++;
        drive_src();
    endtask

    // one clock cycle: sample on negedge, score, then update the source after posedge
    task automatic tick();
        logic [9:0] e;
        @(negedge clk);
        s_ren   = fifo_ren;   s_reoc  = fifo_reoc; s_raddr = fifo_raddr;
        s_valid = valid;      s_ready = ready;     s_data  = data;
        s_sop   = sop;        s_eop   = eop;       s_busy  = busy;
        s_cnt   = cell_cnt;   s_state = dbg_state;
        if (s_ren) begin
            ren_n++;
            ren_cyc_q.push_back(cyc);
            check("raddr", 32'(s_raddr), 32'(exp_raddr));
            check("reoc_on_last", 32'(s_reoc), 32'(exp_raddr == 2'd3));
            exp_raddr = (exp_raddr == 2'd3) ? 2'd0 : exp_raddr + 2'd1;
        end
        if (s_reoc) begin
            reoc_n++;
            check("reoc_with_ren", 32'(s_ren), 32'd1);
        end
        if (s_valid && s_ready) begin
            out_n++;
            out_cyc_q.push_back(cyc);
            if (s_sop) sop_n++;
            if (s_eop) eop_n++;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 'x;
            check("out_word", 32'({s_sop, s_eop, s_data}), 32'(e));
        end
        @(posedge clk);
        #1;
        if (s_ren && src_q.size() > 0) begin
            void'(src_q.pop_front());
            if (s_reoc && src_cells > 0) src_cells--;
        end
        drive_src();
        if (rand_ready) ready = 1'($urandom_range(0, 1));
        cyc++;
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        ren_cyc_q.delete();
        out_cyc_q.delete();
        src_cells = 0;
        exp_raddr = 2'd0;
        ren_n = 0; reoc_n = 0; out_n = 0; sop_n = 0; eop_n = 0;
        drive_src();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        rand_ready = 1'b0;
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ren"},   32'(s_ren),   32'd0);
        check({tag, "_reoc"},  32'(s_reoc),  32'd0);
        check({tag, "_raddr"}, 32'(s_raddr), 32'd0);
        check({tag, "_valid"}, 32'(s_valid), 32'd0);
        check({tag, "_sop"},   32'(s_sop),   32'd0);
        check({tag, "_eop"},   32'(s_eop),   32'd0);
        check({tag, "_data"},  32'(s_data),  32'd0);
        check({tag, "_busy"},  32'(s_busy),  32'd0);
        check({tag, "_cnt"},   32'(s_cnt),   32'd0);
        check({tag, "_state"}, 32'(s_state), 32'd0);
    endtask

    task automatic drain(input int max_cyc, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (src_q.size() == 0 && exp_q.size() == 0 && !s_busy) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // directed sequence
    initial begin
        int   load_cyc;
        logic got;

        rst_n = 1'b0; ready = 1'b0; fifo_empty = 1'b1; fifo_rdata = 8'h00;

        // reset state
        do_reset();
        check_zero("rst");

        // single cell A0..A3, ready high
        ready = 1'b1;
        load_cyc = cyc;
        load_cell(8'hA0);
        drain(40, "one_drain");
        check("one_ren_n", 32'(ren_n), 32'd4);
        check("one_first_ren", 32'(ren_cyc_q[0]), 32'(load_cyc + 1));
        for (int i = 1; i < 4; i++) begin
            check("one_ren_step", 32'(ren_cyc_q[i] - ren_cyc_q[0]), 32'(i));
        end
        check("one_out_n", 32'(out_n), 32'd4);
        check("one_latency", 32'(out_cyc_q[0] - ren_cyc_q[0]), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check("one_out_step", 32'(out_cyc_q[i] - out_cyc_q[0]), 32'(i));
        end
        check("one_sop_eop", 32'({sop_n[7:0], eop_n[7:0]}), 32'h0101);
        check("one_cnt", 32'(s_cnt), 32'd1);

        // three queued cells, ready high
        do_reset();
        ready = 1'b1;
        load_cyc = cyc;
        load_cell(8'h10);
        load_cell(8'h14);
        load_cell(8'h18);
        drain(80, "three_drain");
        check("three_ren_n", 32'(ren_n), 32'd12);
        check("three_first_ren", 32'(ren_cyc_q[0]), 32'(load_cyc + 1));
        check("three_ren_span", 32'(ren_cyc_q[11] - ren_cyc_q[0]), 32'd13);
        check("three_out_n", 32'(out_n), 32'd12);
        check("three_out_span", 32'(out_cyc_q[11] - out_cyc_q[0]), 32'd13);
        check("three_gap1", 32'(out_cyc_q[4] - out_cyc_q[3]), 32'd2);
        check("three_gap2", 32'(out_cyc_q[8] - out_cyc_q[7]), 32'd2);
        check("three_inner", 32'(out_cyc_q[1] - out_cyc_q[0]), 32'd1);
        check("three_cnt", 32'(s_cnt), 32'd3);
        for (int i = 0; i < 3; i++) tick();
        check("three_idle_state", 32'(s_state), 32'd0);
        check("three_idle_ren_n", 32'(ren_n), 32'd12);

        // backpressure: ready low for 5 cycles from first valid
        do_reset();
        ready = 1'b0;
        load_cell(8'hA0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 32'(got), 32'd1);
        check("bp_hold0", 32'(s_data), 32'hA0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_valid", 32'(s_valid), 32'd1);
            check("bp_hold_data", 32'({s_sop, s_data}), 32'h1A0);
        end
        check("bp_ren_max", 32'(ren_n), 32'd2);
        ready = 1'b1;
        drain(40, "bp_drain");
        check("bp_out_n", 32'(out_n), 32'd4);
        check("bp_ren_n", 32'(ren_n), 32'd4);
        check("bp_cnt", 32'(s_cnt), 32'd1);

        // 100 cells of counting data with random ready
        do_reset();
        for (int c = 0; c < 100; c++) load_cell(8'(4 * c));
        rand_ready = 1'b1;
        drain(5000, "rnd_drain");
        rand_ready = 1'b0;
        check("rnd_out_n", 32'(out_n), 32'd400);
        check("rnd_sop_n", 32'(sop_n), 32'd100);
        check("rnd_eop_n", 32'(eop_n), 32'd100);
        check("rnd_cnt", 32'(s_cnt), 32'd100);

        // reset mid-cell after raddr=1
        do_reset();
        ready = 1'b1;
        load_cell(8'h50);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_ren && s_raddr == 2'd1) begin
                got = 1'b1;
                break;
            end
        end
        check("mid_raddr1_seen", 32'(got), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ren", 32'(s_ren), 32'd0);
        check("mid_rst_reoc", 32'(s_reoc), 32'd0);
        clear_model();
        tick();
        check_zero("mid");
        check("mid_no_reoc", 32'(reoc_n), 32'd0);
        rst_n = 1'b1;

        // counter wrap from 0xFFFF
        do_reset();
        force dut.cell_cnt = 16'hFFFF;
        tick();
        release dut.cell_cnt;
        tick();
        check("wrap_preset", 32'(s_cnt), 32'hFFFF);
        ready = 1'b1;
        load_cell(8'hC0);
        drain(40, "wrap_drain");
        check("wrap_cnt", 32'(s_cnt), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
